// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: PC register, imem valid/ready request and IF/ID pipeline register.
// Optional HALT-opcode detection is enabled by defining HALT_DETECT_EN.
module instr_fetch_stage #(
  parameter int              ADDR_W      = 16,
  parameter int              INSTR_W     = 16,
  parameter int              INSTR_BYTES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]      HALT_OP     = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_next,
  output logic               halted,
  output logic [1:0]         fsm_state
);

  // Handshake: a fetch completes on a cycle where imem_req and imem_ready are both high;
  // while imem_req=1 and imem_ready=0 the address (pc) is held stable.
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, pc_inc;
  logic                valid_n;
  logic [INSTR_W-1:0]  instr_n;
  logic [ADDR_W-1:0]   id_pc_n, id_pc_next_n;
  logic                is_halt_op;

  assign pc_inc     = pc + STEP;
  assign is_halt_op = HALT_EN && (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    valid_n      = if_id_valid;
    instr_n      = if_id_instr;
    id_pc_n      = if_id_pc;
    id_pc_next_n = if_id_pc_next;
    imem_req     = ~rst && (state != S_HALT);
    imem_addr    = pc;
    halted       = HALT_EN && (state == S_HALT);
    fsm_state    = state;

    if (branch_taken) begin
      // Redirect wins over stall and any in-flight response.
      pc_n    = branch_target & ALIGN_MASK;
      valid_n = 1'b0;
      state_n = S_RUN;
    end else if (state == S_HALT) begin
      valid_n = 1'b0;
    end else if (stall) begin
      // Hold everything; the response (if any) is dropped and refetched later.
    end else if (imem_ready) begin
      valid_n      = 1'b1;
      instr_n      = imem_rdata;
      id_pc_n      = pc;
      id_pc_next_n = pc_inc;
      if (is_halt_op) begin
        state_n = S_HALT;
      end else begin
        pc_n    = pc_inc;
        state_n = S_RUN;
      end
    end else begin
      valid_n = 1'b0;
      state_n = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      pc            <= RESET_PC;
      if_id_valid   <= 1'b0;
      if_id_instr   <= '0;
      if_id_pc      <= '0;
      if_id_pc_next <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      if_id_valid   <= valid_n;
      if_id_instr   <= instr_n;
      if_id_pc      <= id_pc_n;
      if_id_pc_next <= id_pc_next_n;
    end
  end

endmodule
